// File: rtl/rtc_pkg.sv
// rtc_pkg: shared widths, limits, state and field_sel encodings for the RTC time-setting controller.
package rtc_pkg;

  localparam int MIN_W   = 6;
  localparam int HOUR_W  = 5;
  localparam int DAY_W   = 5;
  localparam int MONTH_W = 4;
  localparam int YEAR_W  = 16;
  localparam int FSEL_W  = 3;

  localparam int HOUR_MAX  = 23;
  localparam int MIN_MAX   = 59;
  localparam int MONTH_MAX = 12;

  typedef logic [2:0] state_t;

  localparam state_t ST_RUN       = 3'd0;
  localparam state_t ST_SET_HOUR  = 3'd1;
  localparam state_t ST_SET_MIN   = 3'd2;
  localparam state_t ST_SET_DAY   = 3'd3;
  localparam state_t ST_SET_MONTH = 3'd4;
  localparam state_t ST_SET_YEAR  = 3'd5;
  localparam state_t ST_COMMIT    = 3'd6;

  localparam logic [FSEL_W-1:0] FS_RUN   = 3'd0;
  localparam logic [FSEL_W-1:0] FS_HOUR  = 3'd1;
  localparam logic [FSEL_W-1:0] FS_MIN   = 3'd2;
  localparam logic [FSEL_W-1:0] FS_DAY   = 3'd3;
  localparam logic [FSEL_W-1:0] FS_MONTH = 3'd4;
  localparam logic [FSEL_W-1:0] FS_YEAR  = 3'd5;

  // COMMIT shows no field: the display stops blinking as the load happens.
  function automatic logic [FSEL_W-1:0] field_of_state(input state_t st);
    logic [FSEL_W-1:0] fs;
    case (st)
      ST_SET_HOUR:  fs = FS_HOUR;
      ST_SET_MIN:   fs = FS_MIN;
      ST_SET_DAY:   fs = FS_DAY;
      ST_SET_MONTH: fs = FS_MONTH;
      ST_SET_YEAR:  fs = FS_YEAR;
      default:      fs = FS_RUN;
    endcase
    return fs;
  endfunction

endpackage

// File: rtl/rtc_days_in_month.sv
// rtc_days_in_month: combinational days-in-month lookup including the Gregorian leap-year rule.
module rtc_days_in_month
  import rtc_pkg::*;
(
  input  logic [MONTH_W-1:0] month,
  input  logic [YEAR_W-1:0]  year,
  output logic [DAY_W-1:0]   dim
);

  logic leap;

  always_comb begin
    leap = ((year % 16'd4) == 16'd0) &&
           (((year % 16'd100) != 16'd0) || ((year % 16'd400) == 16'd0));
    case (month)
      4'd2:                    dim = leap ? 5'd29 : 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11: dim = 5'd30;
      default:                 dim = 5'd31;
    endcase
  end

endmodule

// File: rtl/rtc_set_ctrl.sv
// rtc_set_ctrl: two-button time/date setting FSM with shadow registers, chain freeze and commit load pulse.
// Define RTC_SET_AUTOREPEAT_EN to build the held-btn_inc auto-repeat counter.
module rtc_set_ctrl
  import rtc_pkg::*;
#(
  parameter int YEAR_MIN = 2000,
  parameter int YEAR_MAX = 2099
`ifdef RTC_SET_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY  = 50_000_000,
  parameter int REPEAT_PERIOD = 12_500_000
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_mode,
  input  logic               btn_inc,
  input  logic [MIN_W-1:0]   cur_minute,
  input  logic [HOUR_W-1:0]  cur_hour,
  input  logic [DAY_W-1:0]   cur_day,
  input  logic [MONTH_W-1:0] cur_month,
  input  logic [YEAR_W-1:0]  cur_year,
  output logic               run_en,
  output logic               load,
  output logic [MIN_W-1:0]   set_second,
  output logic [MIN_W-1:0]   set_minute,
  output logic [HOUR_W-1:0]  set_hour,
  output logic [DAY_W-1:0]   set_day,
  output logic [MONTH_W-1:0] set_month,
  output logic [YEAR_W-1:0]  set_year,
  output logic [FSEL_W-1:0]  field_sel
);

  localparam logic [YEAR_W-1:0]  YMIN   = YEAR_W'(YEAR_MIN);
  localparam logic [YEAR_W-1:0]  YMAX   = YEAR_W'(YEAR_MAX);
  localparam logic [HOUR_W-1:0]  HMAX   = HOUR_W'(HOUR_MAX);
  localparam logic [MIN_W-1:0]   MMAX   = MIN_W'(MIN_MAX);
  localparam logic [MONTH_W-1:0] MOMAX  = MONTH_W'(MONTH_MAX);

  state_t state_q, state_d;
  logic   mode_prev_q, inc_prev_q;
  logic   mode_press, inc_press;
  logic   in_set, inc_evt, rpt_tick;

  logic [MIN_W-1:0]   minute_q, minute_d;
  logic [HOUR_W-1:0]  hour_q, hour_d;
  logic [DAY_W-1:0]   day_q, day_d, day_raw;
  logic [MONTH_W-1:0] month_q, month_d;
  logic [YEAR_W-1:0]  year_q, year_d;
  logic               day_inc;
  logic [DAY_W-1:0]   dim;

  logic               run_en_q, run_en_d;
  logic               load_q, load_d;
  logic [FSEL_W-1:0]  field_sel_q, field_sel_d;

  assign mode_press = btn_mode & ~mode_prev_q;
  assign inc_press  = btn_inc & ~inc_prev_q;
  assign in_set     = (state_q != ST_RUN) && (state_q != ST_COMMIT);
  assign inc_evt    = in_set && !mode_press && (inc_press || rpt_tick);

  // Looks at the next month/year so the day clamp lands in the same update.
  rtc_days_in_month u_dim (
    .month (month_d),
    .year  (year_d),
    .dim   (dim)
  );

  always_comb begin
    state_d  = state_q;
    minute_d = minute_q;
    hour_d   = hour_q;
    day_raw  = day_q;
    month_d  = month_q;
    year_d   = year_q;
    day_inc  = 1'b0;
    if (state_q == ST_COMMIT) begin
      state_d = ST_RUN;
    end else if (mode_press) begin
      case (state_q)
        ST_RUN: begin
          state_d  = ST_SET_HOUR;
          hour_d   = (cur_hour > HMAX) ? HMAX : cur_hour;
          minute_d = (cur_minute > MMAX) ? MMAX : cur_minute;
          if (cur_month == '0)      month_d = MONTH_W'(1);
          else if (cur_month > MOMAX) month_d = MOMAX;
          else                      month_d = cur_month;
          year_d   = ((cur_year < YMIN) || (cur_year > YMAX)) ? YMIN : cur_year;
          day_raw  = (cur_day == '0) ? DAY_W'(1) : cur_day;
        end
        ST_SET_HOUR:  state_d = ST_SET_MIN;
        ST_SET_MIN:   state_d = ST_SET_DAY;
        ST_SET_DAY:   state_d = ST_SET_MONTH;
        ST_SET_MONTH: state_d = ST_SET_YEAR;
        ST_SET_YEAR:  state_d = ST_COMMIT;
        default:      state_d = ST_RUN;
      endcase
    end else if (inc_evt) begin
      case (state_q)
        ST_SET_HOUR:  hour_d   = (hour_q >= HMAX) ? '0 : hour_q + 1'b1;
        ST_SET_MIN:   minute_d = (minute_q >= MMAX) ? '0 : minute_q + 1'b1;
        ST_SET_DAY:   day_inc  = 1'b1;
        ST_SET_MONTH: month_d  = (month_q >= MOMAX) ? MONTH_W'(1) : month_q + 1'b1;
        ST_SET_YEAR:  year_d   = (year_q >= YMAX) ? YMIN : year_q + 1'b1;
        default:      ;
      endcase
    end
  end

  always_comb begin
    day_d = day_raw;
    if (day_inc)            day_d = (day_q >= dim) ? DAY_W'(1) : day_q + 1'b1;
    else if (day_raw > dim) day_d = dim;
  end

  always_comb begin
    run_en_d    = (state_d == ST_RUN);
    load_d      = (state_d == ST_COMMIT);
    field_sel_d = field_of_state(state_d);
  end

`ifdef RTC_SET_AUTOREPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
  logic             inc_held;

  assign inc_held = btn_inc & inc_prev_q;
  // Zero means idle; a tick fires as the down-counter reaches one.
  assign rpt_tick = in_set && inc_held && (rpt_cnt_q == RPT_W'(1));

  always_comb begin
    rpt_cnt_d = '0;
    if (state_d != state_q)
      rpt_cnt_d = '0;
    else if (in_set && inc_press)
      rpt_cnt_d = RPT_W'(REPEAT_DELAY);
    else if (inc_held && (rpt_cnt_q != '0))
      rpt_cnt_d = rpt_tick ? RPT_W'(REPEAT_PERIOD) : rpt_cnt_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rpt_cnt_q <= '0;
    else     rpt_cnt_q <= rpt_cnt_d;
  end
`else
  assign rpt_tick = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RUN;
      mode_prev_q <= 1'b0;
      inc_prev_q  <= 1'b0;
      minute_q    <= '0;
      hour_q      <= '0;
      day_q       <= DAY_W'(1);
      month_q     <= MONTH_W'(1);
      year_q      <= YMIN;
      run_en_q    <= 1'b1;
      load_q      <= 1'b0;
      field_sel_q <= FS_RUN;
    end else begin
      state_q     <= state_d;
      mode_prev_q <= btn_mode;
      inc_prev_q  <= btn_inc;
      minute_q    <= minute_d;
      hour_q      <= hour_d;
      day_q       <= day_d;
      month_q     <= month_d;
      year_q      <= year_d;
      run_en_q    <= run_en_d;
      load_q      <= load_d;
      field_sel_q <= field_sel_d;
    end
  end

  assign run_en     = run_en_q;
  assign load       = load_q;
  assign field_sel  = field_sel_q;
  assign set_second = '0;
  assign set_minute = minute_q;
  assign set_hour   = hour_q;
  assign set_day    = day_q;
  assign set_month  = month_q;
  assign set_year   = year_q;

endmodule

// File: tb/tb_rtc_set_ctrl.sv
// tb_rtc_set_ctrl: directed and randomized checks of rtc_set_ctrl against a calendar-level reference model.
module tb_rtc_set_ctrl;

`ifdef RTC_SET_AUTOREPEAT_EN
  localparam int RD = 10;
  localparam int RP = 4;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        btn_mode = 1'b0;
  logic        btn_inc = 1'b0;
  logic [5:0]  cur_minute = '0;
  logic [4:0]  cur_hour = '0;
  logic [4:0]  cur_day = 5'd1;
  logic [3:0]  cur_month = 4'd1;
  logic [15:0] cur_year = 16'd2000;
  logic        run_en, load;
  logic [5:0]  set_second, set_minute;
  logic [4:0]  set_hour, set_day;
  logic [3:0]  set_month;
  logic [15:0] set_year;
  logic [2:0]  field_sel;
  logic [46:0] dut_vec;

  int checks = 0;
  int errors = 0;

  // Reference model: step 0 = running, 1..5 = hour/minute/day/month/year edit, 6 = commit.
  int m_step, m_hour, m_min, m_day, m_month, m_year;
  bit m_pm, m_pi;
`ifdef RTC_SET_AUTOREPEAT_EN
  bit m_armed;
  int m_k;
`endif

  always #5 clk = ~clk;

  rtc_set_ctrl #(
    .YEAR_MIN(2000),
    .YEAR_MAX(2099)
`ifdef RTC_SET_AUTOREPEAT_EN
    ,
    .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP)
`endif
  ) dut (
    .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .cur_minute(cur_minute), .cur_hour(cur_hour), .cur_day(cur_day),
    .cur_month(cur_month), .cur_year(cur_year),
    .run_en(run_en), .load(load), .set_second(set_second), .set_minute(set_minute),
    .set_hour(set_hour), .set_day(set_day), .set_month(set_month), .set_year(set_year),
    .field_sel(field_sel)
  );

  assign dut_vec = {run_en, load, field_sel, set_second, set_minute, set_hour,
                    set_day, set_month, set_year};

  function automatic int dim_of(input int mo, input int y);
    int  t[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
    bit  leap;
    leap = ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0);
    if (mo == 2 && leap) return 29;
    return t[mo-1];
  endfunction

  function automatic logic [46:0] exp_vec();
    logic [2:0] fs;
    fs = (m_step >= 1 && m_step <= 5) ? 3'(m_step) : 3'd0;
    return {(m_step == 0), (m_step == 6), fs, 6'd0, 6'(m_min), 5'(m_hour),
            5'(m_day), 4'(m_month), 16'(m_year)};
  endfunction

  task automatic model_reset();
    m_step = 0; m_hour = 0; m_min = 0; m_day = 1; m_month = 1; m_year = 2000;
    m_pm = 0; m_pi = 0;
`ifdef RTC_SET_AUTOREPEAT_EN
    m_armed = 0; m_k = 0;
`endif
  endtask

  task automatic model_step();
    bit mp, ip, do_inc;
    int old;
    mp = btn_mode && !m_pm;
    ip = btn_inc && !m_pi;
    old = m_step;
    do_inc = 0;
    if (m_step == 6) m_step = 0;
    else if (mp) begin
      if (m_step == 0) begin
        m_hour  = (cur_hour > 23) ? 23 : int'(cur_hour);
        m_min   = (cur_minute > 59) ? 59 : int'(cur_minute);
        m_month = (cur_month == 0) ? 1 : (cur_month > 12) ? 12 : int'(cur_month);
        m_year  = (cur_year < 2000 || cur_year > 2099) ? 2000 : int'(cur_year);
        m_day   = (cur_day == 0) ? 1 : int'(cur_day);
        if (m_day > dim_of(m_month, m_year)) m_day = dim_of(m_month, m_year);
      end
      m_step++;
    end else if (m_step >= 1 && ip) do_inc = 1;
`ifdef RTC_SET_AUTOREPEAT_EN
    if (m_step != old || !btn_inc) m_armed = 0;
    else if (ip && old >= 1 && old <= 5) begin m_armed = 1; m_k = 0; end
    else if (m_armed) m_k++;
    if (m_armed && m_k > 0 && (m_k == RD || (m_k > RD && (m_k - RD) % RP == 0)))
      do_inc = 1;
`endif
    if (do_inc) begin
      case (m_step)
        1: m_hour = (m_hour + 1) % 24;
        2: m_min  = (m_min + 1) % 60;
        3: m_day  = (m_day >= dim_of(m_month, m_year)) ? 1 : m_day + 1;
        4: m_month = m_month % 12 + 1;
        5: m_year = (m_year >= 2099) ? 2000 : m_year + 1;
        default: ;
      endcase
      if (m_day > dim_of(m_month, m_year)) m_day = dim_of(m_month, m_year);
    end
    m_pm = btn_mode;
    m_pi = btn_inc;
  endtask

  task automatic cycle(input logic m, input logic i);
    btn_mode = m;
    btn_inc  = i;
    @(posedge clk);
    if (rst) model_reset();
    else     model_step();
    #1;
  endtask

  task automatic go_run();
    for (int n = 0; n < 8 && m_step != 0; n++) begin
      cycle(1'b1, 1'b0);
      cycle(1'b0, 1'b0);
    end
    cycle(1'b0, 1'b0);
  endtask

  task automatic set_cur(input int h, input int mi, input int d, input int mo, input int y);
    cur_hour = 5'(h); cur_minute = 6'(mi); cur_day = 5'(d); cur_month = 4'(mo); cur_year = 16'(y);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    checks++;
    if (dut_vec !== 47'({1'b1, 1'b0, 3'd0, 6'd0, 6'd0, 5'd0, 5'd1, 4'd1, 16'd2000})) begin
      errors++; $display("FAIL reset_vec got %h exp %h", dut_vec,
        47'({1'b1, 1'b0, 3'd0, 6'd0, 6'd0, 5'd0, 5'd1, 4'd1, 16'd2000}));
    end
    rst = 1'b0;
    for (int n = 0; n < 3; n++) begin
      cycle(1'b0, 1'b0);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL reset_idle got %h exp %h", dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_hour_wrap();
    go_run();
    set_cur(13, 45, 29, 2, 2024);
    cycle(1'b1, 1'b0);
    checks++;
    if (run_en !== 1'b0 || field_sel !== 3'd1 || set_hour !== 5'd13) begin
      errors++; $display("FAIL enter_edit got run_en=%b fs=%0d hour=%0d exp 0 1 13",
                         run_en, field_sel, set_hour);
    end
    cycle(1'b0, 1'b0);
    for (int n = 0; n < 11; n++) begin
      cycle(1'b0, 1'b1);
      cycle(1'b0, 1'b0);
    end
    checks++;
    if (set_hour !== 5'd0 || dut_vec !== exp_vec()) begin
      errors++; $display("FAIL hour_wrap got hour=%0d vec=%h exp 0 vec=%h", set_hour, dut_vec, exp_vec());
    end
  endtask

  task automatic test_year_clamp();
    go_run();
    set_cur(10, 20, 29, 2, 2024);
    for (int n = 0; n < 5; n++) begin cycle(1'b1, 1'b0); cycle(1'b0, 1'b0); end
    checks++;
    if (field_sel !== 3'd5 || set_day !== 5'd29) begin
      errors++; $display("FAIL year_entry got fs=%0d day=%0d exp 5 29", field_sel, set_day);
    end
    cycle(1'b0, 1'b1);
    checks++;
    if (set_year !== 16'd2025 || set_day !== 5'd28) begin
      errors++; $display("FAIL year_leap_clamp got %0d/%0d exp 2025/28", set_year, set_day);
    end
    cycle(1'b0, 1'b0);
    go_run();
    set_cur(10, 20, 28, 2, 2099);
    for (int n = 0; n < 5; n++) begin cycle(1'b1, 1'b0); cycle(1'b0, 1'b0); end
    cycle(1'b0, 1'b1);
    checks++;
    if (set_year !== 16'd2000 || set_day !== 5'd28 || set_month !== 4'd2) begin
      errors++; $display("FAIL year_wrap got %0d/%0d/%0d exp 2000/2/28", set_year, set_month, set_day);
    end
    cycle(1'b0, 1'b0);
  endtask

  task automatic test_month_clamp();
    int years[2] = '{2024, 2023};
    int exp_d[2] = '{29, 28};
    for (int t = 0; t < 2; t++) begin
      go_run();
      set_cur(1, 2, 31, 1, years[t]);
      for (int n = 0; n < 4; n++) begin cycle(1'b1, 1'b0); cycle(1'b0, 1'b0); end
      cycle(1'b0, 1'b1);
      checks++;
      if (field_sel !== 3'd4 || set_month !== 4'd2 || set_day !== 5'(exp_d[t])) begin
        errors++; $display("FAIL month_clamp y=%0d got fs=%0d m=%0d d=%0d exp 4 2 %0d",
                           years[t], field_sel, set_month, set_day, exp_d[t]);
      end
      cycle(1'b0, 1'b0);
    end
  endtask

  task automatic test_full_pass();
    int loads;
    go_run();
    set_cur(7, 30, 15, 6, 2050);
    loads = 0;
    for (int n = 0; n < 6; n++) begin
      cycle(1'b1, 1'b0);
      if (load === 1'b1) loads++;
      if (n == 5) begin
        checks++;
        if (load !== 1'b1 || run_en !== 1'b0 || set_second !== 6'd0) begin
          errors++; $display("FAIL commit_cycle got load=%b run_en=%b sec=%0d exp 1 0 0",
                             load, run_en, set_second);
        end
      end
      cycle(1'b0, 1'b0);
      if (load === 1'b1) loads++;
    end
    checks++;
    if (loads !== 1 || run_en !== 1'b1 || field_sel !== 3'd0) begin
      errors++; $display("FAIL full_pass got loads=%0d run_en=%b fs=%0d exp 1 1 0", loads, run_en, field_sel);
    end
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b1);
    checks++;
    if (field_sel !== 3'd2 || set_hour !== 5'd7 || set_minute !== 6'd30) begin
      errors++; $display("FAIL mode_beats_inc got fs=%0d h=%0d m=%0d exp 2 7 30", field_sel, set_hour, set_minute);
    end
    cycle(1'b0, 1'b0);
  endtask

  task automatic test_random();
    go_run();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        cur_hour   = 5'($urandom_range(0, 31));
        cur_minute = 6'($urandom_range(0, 63));
        cur_day    = 5'($urandom_range(0, 31));
        cur_month  = 4'($urandom_range(0, 15));
        cur_year   = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(2000, 2099));
      end
      cycle(($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0) ? ~btn_inc : btn_inc);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL random cyc=%0d got %h exp %h", n, dut_vec, exp_vec());
      end
    end
    cycle(1'b0, 1'b0);
  endtask

`ifdef RTC_SET_AUTOREPEAT_EN
  task automatic test_autorepeat();
    go_run();
    set_cur(4, 58, 3, 3, 2030);
    cycle(1'b1, 1'b0); cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b0); cycle(1'b0, 1'b0);
    for (int n = 0; n <= 22; n++) begin
      cycle(1'b0, 1'b1);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL autorepeat j=%0d got %h exp %h", n, dut_vec, exp_vec());
      end
    end
    checks++;
    if (set_minute !== 6'd3 || field_sel !== 3'd2) begin
      errors++; $display("FAIL autorepeat_final got min=%0d fs=%0d exp 3 2", set_minute, field_sel);
    end
    cycle(1'b0, 1'b1);
    rst = 1'b1;
    #1;
    model_reset();
    checks++;
    if (dut_vec !== exp_vec() || run_en !== 1'b1 || load !== 1'b0) begin
      errors++; $display("FAIL rst_mid_hold got %h exp %h", dut_vec, exp_vec());
    end
    cycle(1'b0, 1'b1);
    rst = 1'b0;
    for (int n = 0; n < 15; n++) cycle(1'b0, 1'b1);
    checks++;
    if (run_en !== 1'b1 || set_minute !== 6'd0 || field_sel !== 3'd0) begin
      errors++; $display("FAIL after_rst_hold got run_en=%b min=%0d fs=%0d exp 1 0 0",
                         run_en, set_minute, field_sel);
    end
    cycle(1'b0, 1'b0);
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_hour_wrap();
    test_year_clamp();
    test_month_clamp();
    test_full_pass();
    test_random();
`ifdef RTC_SET_AUTOREPEAT_EN
    test_autorepeat();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rtc_set_ctrl.md
# rtc_set_ctrl

- Time-setting controller for the real-time clock/calendar counter chain.
- Takes two pre-synchronised push-button levels (mode, increment) and walks the user through hour, minute, day, month and year.
- Holds edited values in shadow registers, freezes the counter chain while editing, and issues a single-cycle load command on commit.
- Sits between the button front-end and the second/minute/hour/day/month/year counters.

## Interface
- YEAR_MIN, 2000, lowest settable year; wrap target above YEAR_MAX
- YEAR_MAX, 2099, highest settable year
- REPEAT_DELAY, 50_000_000, cycles btn_inc must be held before auto-repeat starts (only with the macro)
- REPEAT_PERIOD, 12_500_000, cycles between auto-repeat increments (only with the macro)
- clk  in  1  system clock; the single clock
- rst  in  1  asynchronous, active-high reset
- btn_mode  in  1  mode button level, already synchronised to clk
- btn_inc  in  1  increment button level, already synchronised to clk
- cur_minute  in  6  live minute from the counter chain
- cur_hour  in  5  live hour
- cur_day  in  5  live day
- cur_month  in  4  live month
- cur_year  in  16  live year
- run_en  out  1  counter-chain enable; 0 while editing
- load  out  1  one-cycle pulse; counters take the set_* values
- set_second  out  6  always 0
- set_minute, set_hour, set_day, set_month, set_year  out  6/5/5/4/16  shadow values
- field_sel  out  3  0=RUN, 1=hour, 2=minute, 3=day, 4=month, 5=year (display blink select)

## Operation
- A press is a rising edge of a button level, detected against a registered copy of the previous level.
- States: RUN, SET_HOUR, SET_MIN, SET_DAY, SET_MONTH, SET_YEAR, COMMIT.
- RUN + mode press:
  - shadows capture the cur_* values
  - next state is SET_HOUR
  - run_en goes to 0
- SET_HOUR→SET_MIN→SET_DAY→SET_MONTH→SET_YEAR on successive mode presses.
- SET_YEAR + mode press → COMMIT.
- COMMIT lasts exactly one cycle:
  - load=1 and run_en=0 in that cycle
  - next state is RUN
- An inc press in a SET_* state increments the selected shadow with wrap:
  - hour 23→0
  - minute 59→0
  - day dim→1, where dim = days in the shadow month/year
  - month 12→1
  - year YEAR_MAX→YEAR_MIN
- Leap year: divisible by 4 and not by 100, or divisible by 400. February has 29 days in a leap year, 28 otherwise.
- Day clamp: whenever the shadow month or year changes, set_day becomes min(set_day, dim) in the same update.
- Inc presses in RUN and COMMIT are ignored.
- A mode press and an inc press in the same cycle: the mode press wins and the inc is discarded.
- Captured cur_* values outside their legal range are clamped on capture: hour>23→23, minute>59→59, month 0→1, month>12→12, day 0→1, day>dim→dim, year outside [YEAR_MIN, YEAR_MAX]→YEAR_MIN.

## Timing
- Reset values:
  - state RUN, run_en=1, load=0, field_sel=0
  - set_second=0, set_minute=0, set_hour=0, set_day=1, set_month=1, set_year=YEAR_MIN
  - previous-level registers 0
- Reset asserted mid-edit returns to RUN with the reset values above and no load pulse.
- Latency: a button edge sampled in cycle N produces the state/shadow/field_sel change in cycle N+1.
- run_en falls in cycle N+1 of the RUN-exit press.
- load is high in the cycle after the SET_YEAR mode press.
- run_en returns to 1 in the following cycle, together with field_sel=0.
- All outputs are registered; no combinational path from the buttons to the outputs.

## Configuration
- RTC_SET_AUTOREPEAT_EN defined:
  - in a SET_* state, btn_inc held continuously for REPEAT_DELAY cycles after its press produces one extra increment
  - one more increment follows every REPEAT_PERIOD cycles while the button stays held
  - the counter clears on release, on any state change, and on reset
- RTC_SET_AUTOREPEAT_EN undefined: only edges increment; no repeat counter is built; REPEAT_* are unused.

## Structure
- Shared package rtc_pkg holds:
  - the state enum
  - field_sel encodings
  - HOUR_MAX=23, MIN_MAX=59, MONTH_MAX=12
  - the field widths (6/5/5/4/16)
- Sub-module rtc_days_in_month: combinational, inputs month[3:0] and year[15:0], output dim[4:0], contains the leap-year rule. Instantiated once on the shadow month/year.

## Test plan
- Reset then idle → run_en=1, load=0, field_sel=0, set_* = 0/0/0/1/1/2000 (second/minute/hour/day/month/year).
- cur = 13:45, 2024-02-29:
  - mode press → next cycle run_en=0, field_sel=1, set_hour=13
  - inc ×11 → set_hour wraps to 0
- Shadow day=29, month=2, year=2024: in SET_YEAR, inc → year 2025 and set_day clamps to 28 in the same cycle. Repeat at year 2099 with YEAR_MAX=2099 → year wraps to 2000 (leap year) and day stays 28.
- Shadow day=31, month=1: in SET_MONTH, inc → month=2, day=29 for a leap year, day=28 otherwise.
- Full pass (mode ×6 from RUN) → exactly one load=1 cycle with set_second=0, then run_en=1. Mode and inc pressed in the same cycle → state advances and the shadow is unchanged.
- With RTC_SET_AUTOREPEAT_EN, REPEAT_DELAY=10, REPEAT_PERIOD=4, inc held 22 cycles in SET_MIN from 58 → increments at press, +10, +14, +18, +22, giving 58→59→0→1→2→3. Assert rst mid-hold → RUN and reset values.
